// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage-register state encoding, control field
// layout and the per-stage bubble values loaded on reset and flush.
package pipe_pkg;

  // Occupancy of a stage register: no entry, main only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // Control field bit positions, shared by every stage that carries them.
  localparam int CTRL_RF_WE      = 0;
  localparam int CTRL_DRAM_WE    = 1;
  localparam int CTRL_NPC_OP_LSB = 2;
  localparam int CTRL_NPC_OP_W   = 2;
  localparam int CTRL_HAVE_INST  = 4;

  // Next-PC selection encodings.
  localparam logic [CTRL_NPC_OP_W-1:0] NPC_HOLD      = 2'd0;
  localparam logic [CTRL_NPC_OP_W-1:0] NPC_PC_PLUS_4 = 2'd1;
  localparam logic [CTRL_NPC_OP_W-1:0] NPC_BRANCH    = 2'd2;
  localparam logic [CTRL_NPC_OP_W-1:0] NPC_JUMP      = 2'd3;

  // Per-stage control widths.
  localparam int ID_EX_CTRL_W  = 12;
  localparam int EX_MEM_CTRL_W = 12;

  // A bubble writes nothing, advances the PC by 4 and carries no instruction.
  function automatic logic [ID_EX_CTRL_W-1:0] bubble_ctrl();
    logic [ID_EX_CTRL_W-1:0] c;
    c = '0;
    c[CTRL_NPC_OP_LSB +: CTRL_NPC_OP_W] = NPC_PC_PLUS_4;
    return c;
  endfunction

  localparam logic [ID_EX_CTRL_W-1:0]  ID_EX_CTRL_RST  = bubble_ctrl();
  localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_CTRL_RST = bubble_ctrl();

endpackage

// File: rtl/pipe_stage_reg_if.sv
// One valid/ready channel between pipeline stages: payload plus control.
// The producer uses the master modport, the consumer the slave modport.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 12
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         ram_clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Count events, stick at all-ones instead of wrapping.
  always_ff @(posedge ram_clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values, independent of statement order between always blocks.
    if (!rst_n || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional skid entry. Main holds the
// head entry shown on out_if; skid absorbs one extra entry so in_ready can come
// from state instead of from out_ready. Also counts back-pressure cycles.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 96,
  parameter int                CTRL_W   = 12,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter int                SKID     = 1,
  parameter int                CNT_W    = 16
) (
  input  logic             ram_clk,
  input  logic             rst_n,
  input  logic             flush,
  pipe_stage_reg_if.slave  in_if,
  pipe_stage_reg_if.master out_if,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_state_e      state, state_nxt;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_ready, out_valid;
  logic              in_xfer, out_xfer;
  logic              load_main_in, load_main_skid, load_skid;

  // Handshake qualifiers; flush blocks both sides so nothing moves while killing.
  always_comb begin
    out_valid = !flush && (state != ST_EMPTY);
    if (SKID != 0) begin
      in_ready = rst_n && !flush && (state != ST_TWO);
    end else begin
      in_ready = rst_n && !flush && ((state == ST_EMPTY) || out_if.ready);
    end
  end

  assign in_xfer      = in_if.valid && in_ready;
  assign out_xfer     = out_valid && out_if.ready;
  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = main_data;
  assign out_if.ctrl  = out_valid ? main_ctrl : CTRL_RST;

  // Next occupancy and which entry register loads from where.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path through
    // the case leaves a signal unassigned and no latch is inferred.
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_xfer) begin
          load_main_in = 1'b1;
          state_nxt    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          // Only reachable with SKID=1; SKID=0 never accepts while full and stalled.
          load_skid = 1'b1;
          state_nxt = ST_TWO;
        end else if (out_xfer) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          load_main_skid = 1'b1;
          state_nxt      = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // State and control fields; reset and flush both turn held entries into bubbles.
  always_ff @(posedge ram_clk) begin
    if (!rst_n || flush) begin
      state     <= ST_EMPTY;
      main_ctrl <= CTRL_RST;
      skid_ctrl <= CTRL_RST;
    end else begin
      state <= state_nxt;
      if (load_main_in) begin
        main_ctrl <= in_if.ctrl;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_ctrl <= in_if.ctrl;
      end
    end
  end

  // Payload registers load only on transfers.
  always_ff @(posedge ram_clk) begin
    // NOTE: wide payload storage is deliberately not reset: valid/ctrl already
    // mark it dead, and a reset would add a load path to every data bit.
    if (load_main_in) begin
      main_data <= in_if.data;
    end else if (load_main_skid) begin
      main_data <= skid_data;
    end
    if (load_skid) begin
      skid_data <= in_if.data;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .ram_clk (ram_clk),
    .rst_n   (rst_n),
    .inc     (out_valid && !out_if.ready),
    .clr     (cnt_clr),
    .q       (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: dut_a uses SKID=1 with a 4-bit stall counter,
// dut_b uses SKID=0. Accepted inputs are queued as expected outputs and a
// negedge monitor pops and compares whenever an output transfer occurs.
module tb_pipe_stage_reg;

  localparam int             DW     = 32;
  localparam int             CW     = 12;
  // Bubble: npc_op = PC+4 (2'd1) at bits [3:2], everything else zero.
  localparam logic [CW-1:0]  BUBBLE = 12'h004;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } entry_t;

  logic       ram_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       flush_a = 1'b0;
  logic       flush_b = 1'b0;
  logic       clr_a   = 1'b0;
  logic       clr_b   = 1'b0;
  logic [3:0]  stall_a;
  logic [15:0] stall_b;

  int tests  = 0;
  int fails  = 0;
  int pops_a = 0;
  int pops_b = 0;
  entry_t exp_a[$];
  entry_t exp_b[$];

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) a_in ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) a_out ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) b_in ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) b_out ();

  always #5 ram_clk = ~ram_clk;

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .CTRL_RST(BUBBLE), .SKID(1), .CNT_W(4)
  ) dut_a (
    .ram_clk   (ram_clk),
    .rst_n     (rst_n),
    .flush     (flush_a),
    .in_if     (a_in),
    .out_if    (a_out),
    .cnt_clr   (clr_a),
    .stall_cnt (stall_a)
  );

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .CTRL_RST(BUBBLE), .SKID(0), .CNT_W(16)
  ) dut_b (
    .ram_clk   (ram_clk),
    .rst_n     (rst_n),
    .flush     (flush_b),
    .in_if     (b_in),
    .out_if    (b_out),
    .cnt_clr   (clr_b),
    .stall_cnt (stall_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ram_clk);
    #1;
  endtask

  // Scoreboard monitor: pop on output transfer, push on input transfer,
  // drop everything a reset or flush kills.
  always @(negedge ram_clk) begin
    if (a_out.valid && a_out.ready) begin
      if (exp_a.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_unexpected: got data %0h expected no output", a_out.data);
      end else begin
        entry_t e;
        e = exp_a.pop_front();
        check("a_out_data", 64'(a_out.data), 64'(e.data));
        check("a_out_ctrl", 64'(a_out.ctrl), 64'(e.ctrl));
        pops_a++;
      end
    end
    if (a_in.valid && a_in.ready) exp_a.push_back('{data: a_in.data, ctrl: a_in.ctrl});
    if (!rst_n || flush_a) exp_a.delete();

    if (b_out.valid && b_out.ready) begin
      if (exp_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected: got data %0h expected no output", b_out.data);
      end else begin
        entry_t e;
        e = exp_b.pop_front();
        check("b_out_data", 64'(b_out.data), 64'(e.data));
        check("b_out_ctrl", 64'(b_out.ctrl), 64'(e.ctrl));
        pops_b++;
      end
    end
    if (b_in.valid && b_in.ready) exp_b.push_back('{data: b_in.data, ctrl: b_in.ctrl});
    if (!rst_n || flush_b) exp_b.delete();
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [13:0] pat;
    int        idx;
    logic      acc;

    a_in.valid  = 1'b1;
    a_in.data   = 32'hDEAD;
    a_in.ctrl   = 12'h01F;
    a_out.ready = 1'b0;
    b_in.valid  = 1'b0;
    b_in.data   = '0;
    b_in.ctrl   = '0;
    b_out.ready = 1'b0;

    // Reset held two cycles with in_valid high: nothing accepted.
    repeat (2) step();
    check("rst_out_valid", 64'(a_out.valid), 64'(0));
    check("rst_out_ctrl", 64'(a_out.ctrl), 64'(BUBBLE));
    check("rst_stall", 64'(stall_a), 64'(0));
    check("rst_in_ready_low", 64'(a_in.ready), 64'(0));
    rst_n      = 1'b1;
    a_in.valid = 1'b0;
    #1;
    check("rst_in_ready_high", 64'(a_in.ready), 64'(1));

    // Streaming, out_ready high: entry i shows up right after its accept edge.
    a_out.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in.valid = 1'b1;
      a_in.data  = 32'(i);
      a_in.ctrl  = 12'h010 | 12'(i);
      step();
      check("stream_valid", 64'(a_out.valid), 64'(1));
      check("stream_data", 64'(a_out.data), 64'(i));
    end
    a_in.valid = 1'b0;
    step();
    check("stream_drained", 64'(a_out.valid), 64'(0));
    check("stream_no_stall", 64'(stall_a), 64'(0));

    // Back-pressure: A into main, B into skid, C held off.
    a_out.ready = 1'b0;
    a_in.valid  = 1'b1;
    a_in.data   = 32'hA;
    a_in.ctrl   = 12'h11A;
    step();
    check("bp_main_a", 64'(a_out.data), 64'hA);
    check("bp_rdy_one", 64'(a_in.ready), 64'(1));
    a_in.data = 32'hB;
    a_in.ctrl = 12'h11B;
    step();
    check("bp_rdy_two", 64'(a_in.ready), 64'(0));
    check("bp_hold_a1", 64'(a_out.data), 64'hA);
    check("bp_stall1", 64'(stall_a), 64'(1));
    a_in.data = 32'hC;
    a_in.ctrl = 12'h11C;
    step();
    check("bp_rdy_two_c", 64'(a_in.ready), 64'(0));
    check("bp_hold_a2", 64'(a_out.data), 64'hA);
    check("bp_stall2", 64'(stall_a), 64'(2));
    a_out.ready = 1'b1;
    step();
    check("bp_main_b", 64'(a_out.data), 64'hB);
    check("bp_rdy_back", 64'(a_in.ready), 64'(1));
    step();
    check("bp_main_c", 64'(a_out.data), 64'hC);
    a_in.valid = 1'b0;
    step();
    check("bp_drained", 64'(a_out.valid), 64'(0));
    check("bp_stall_final", 64'(stall_a), 64'(2));

    // Flush in state TWO with a new entry offered in the flush cycle.
    a_out.ready = 1'b0;
    a_in.valid  = 1'b1;
    a_in.data   = 32'hD;
    a_in.ctrl   = 12'h11D;
    step();
    a_in.data = 32'hE;
    a_in.ctrl = 12'h11E;
    step();
    check("fl_two", 64'(a_in.ready), 64'(0));
    a_in.data = 32'hF;
    a_in.ctrl = 12'h11F;
    flush_a   = 1'b1;
    #1;
    check("fl_out_valid", 64'(a_out.valid), 64'(0));
    check("fl_in_ready", 64'(a_in.ready), 64'(0));
    step();
    flush_a    = 1'b0;
    a_in.valid = 1'b0;
    #1;
    check("fl_empty", 64'(a_out.valid), 64'(0));
    check("fl_ctrl_bubble", 64'(a_out.ctrl), 64'(BUBBLE));
    check("fl_rdy_after", 64'(a_in.ready), 64'(1));
    check("fl_stall_kept", 64'(stall_a), 64'(3));
    a_out.ready = 1'b1;
    repeat (3) step();
    check("fl_no_ghost", 64'(a_out.valid), 64'(0));

    // Saturation: clear in a stall cycle, then stall for 20 cycles.
    a_out.ready = 1'b0;
    a_in.valid  = 1'b1;
    a_in.data   = 32'h6;
    a_in.ctrl   = 12'h116;
    step();
    a_in.valid = 1'b0;
    check("sat_pre", 64'(stall_a), 64'(3));
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    check("clr_with_stall", 64'(stall_a), 64'(0));
    repeat (15) step();
    check("sat_reach_max", 64'(stall_a), 64'(15));
    repeat (5) step();
    check("sat_hold_max", 64'(stall_a), 64'(15));
    a_out.ready = 1'b1;
    step();
    check("sat_drained", 64'(a_out.valid), 64'(0));

    // Reset mid-transfer discards the held entry and the offered one.
    a_out.ready = 1'b0;
    a_in.valid  = 1'b1;
    a_in.data   = 32'h77;
    a_in.ctrl   = 12'h177;
    step();
    a_in.data = 32'h78;
    rst_n     = 1'b0;
    step();
    check("mid_rst_valid", 64'(a_out.valid), 64'(0));
    check("mid_rst_ctrl", 64'(a_out.ctrl), 64'(BUBBLE));
    check("mid_rst_stall", 64'(stall_a), 64'(0));
    rst_n       = 1'b1;
    a_in.valid  = 1'b0;
    a_out.ready = 1'b1;
    repeat (2) step();
    check("mid_rst_no_ghost", 64'(a_out.valid), 64'(0));

    // SKID=0: out_ready pattern per cycle, c0 first: 1,1,0,1,0,0,1,1,...
    pat = 14'b11111111001011;
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      b_out.ready = pat[c];
      b_in.valid  = (idx < 6);
      b_in.data   = 32'h100 + 32'(idx);
      b_in.ctrl   = 12'h020 + 12'(idx);
      @(negedge ram_clk);
      if (b_out.valid) check("b_rdy_follow", 64'(b_in.ready), 64'(b_out.ready));
      acc = b_in.valid && b_in.ready;
      step();
      if (acc) idx++;
    end
    b_in.valid = 1'b0;
    check("b_all_sent", 64'(idx), 64'(6));
    check("b_stall", 64'(stall_b), 64'(3));

    step();
    check("a_pop_count", 64'(pops_a), 64'(12));
    check("b_pop_count", 64'(pops_b), 64'(6));
    check("a_queue_empty", 64'(exp_a.size()), 64'(0));
    check("b_queue_empty", 64'(exp_b.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
